mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares one single-port memory between instruction fetch (I, read-only) and the data stage (D, read/write).
//   Sits between the processor datapath's fetch/memory stages and the memory model.
//   Data has priority, with a starvation guard for fetch. Provides a per-transaction timeout with error flag.
// PARAMETERS
//   DWIDTH        32  data width (I/D/memory read and write data)
//   AWIDTH_MEM    32  memory address width
//   TIMEOUT       16  max cycles a_o_m_req stays high awaiting a_i_m_ack (>=2)
//   MAX_D_STREAK  4   consecutive D grants allowed while I pending (>=1)
// PORTS
//   a_clk        in   1           clock, rising edge
//   a_rst        in   1           asynchronous active-high reset
//   a_i_i_req    in   1           fetch request; held with addr stable until a_o_i_ack
//   a_i_i_addr   in   AWIDTH_MEM  fetch address
//   a_o_i_ack    out  1           1-cycle fetch completion pulse
//   a_o_i_rdata  out  DWIDTH      fetch data, valid with a_o_i_ack
//   a_i_d_req    in   1           data request; held with we/addr/wdata stable until a_o_d_ack
//   a_i_d_we     in   1           1=write, 0=read
//   a_i_d_addr   in   AWIDTH_MEM  data address
//   a_i_d_wdata  in   DWIDTH      write data
//   a_o_d_ack    out  1           1-cycle data completion pulse
//   a_o_d_rdata  out  DWIDTH      read data, valid with a_o_d_ack (0 on write)
//   a_o_m_req    out  1           memory request, held until a_i_m_ack or timeout
//   a_o_m_we     out  1           memory write enable
//   a_o_m_addr   out  AWIDTH_MEM  memory address
//   a_o_m_wdata  out  DWIDTH      memory write data
//   a_i_m_ack    in   1           memory completion, 1 cycle; a_i_m_rdata valid with it
//   a_i_m_rdata  in   DWIDTH      memory read data
//   a_o_err      out  1           pulses with the I/D ack when that transaction timed out
//   a_o_busy     out  1           1 in any state other than IDLE
// BEHAVIOUR
//   - Reset (async, a_rst=1): state=IDLE, all outputs 0, timeout and streak counters 0.
//     Reset mid-transaction drops it silently; the memory must tolerate a_o_m_req falling without an ack.
//   - FSM: IDLE -> BUSY_I|BUSY_D -> RESP -> IDLE. All outputs are registered.
//   - IDLE, grant decision:
//     - D only -> BUSY_D; I only -> BUSY_I.
//     - Both pending -> BUSY_D, unless streak==MAX_D_STREAK, then BUSY_I.
//     - On entry to BUSY: latch we/addr/wdata into a_o_m_*; a_o_m_req=1; a_o_m_we=0 for I.
//   - Streak counter:
//     - +1 on a D grant while a_i_i_req=1.
//     - Cleared on any I grant, or on a D grant with a_i_i_req=0.
//     - Saturates at MAX_D_STREAK.
//   - BUSY:
//     - a_o_m_* held stable. Timeout counter starts at 0 on entry and +1 per cycle without a_i_m_ack.
//     - a_i_m_ack=1 -> RESP: capture a_i_m_rdata (0 if write), a_o_err=0.
//     - Else if counter==TIMEOUT-1 -> RESP: rdata=0, a_o_err=1.
//     - a_o_m_req is therefore high for at most TIMEOUT cycles. Ack on the final cycle wins over timeout.
//   - RESP (1 cycle):
//     - a_o_m_req=0, a_o_m_we=0.
//     - The granted side's ack=1 with rdata; the other side's ack stays 0.
//     - a_o_err is asserted only in RESP.
//   - Any request seen in IDLE is new. A requester may raise its next request in the cycle after its ack.
//   - Latency: req seen at edge N -> a_o_m_req from N+1. Zero-wait memory (ack in N+1) -> requester ack at N+2.
//     Minimum 3 cycles per transaction.
//   - a_i_m_ack outside BUSY is ignored. Request inputs are not sampled outside IDLE.
// TESTING
//   1 I-fetch:
//     - Stimulus: a_i_i_req=1, addr=0x40; memory acks 1 cycle after a_o_m_req, rdata=0x20020005.
//     - Response: a_o_m_req, addr=0x40, we=0; a_o_i_ack 1 cycle later with rdata=0x20020005, err=0, a_o_d_ack=0.
//   2 D write:
//     - Stimulus: we=1, addr=0x100, wdata=0xDEADBEEF.
//     - Response: a_o_m_we=1, a_o_m_wdata=0xDEADBEEF; a_o_d_ack pulse with rdata=0; a_o_i_ack stays 0.
//   3 Contention: I and D held continuously, zero-wait memory, requesters re-raise requests immediately.
//     - Response: grant order D,D,D,D,I,D,D,D,D,I (MAX_D_STREAK=4).
//   4 Timeout: D read, memory never acks.
//     - Response: a_o_m_req high exactly 16 cycles, then a_o_d_ack=1, a_o_err=1, rdata=0; next cycle IDLE, busy=0.
//   5 Late ack: memory acks on the 16th BUSY cycle with 0x1234.
//     - Response: a_o_d_ack with 0x1234, a_o_err=0.
//   6 Reset mid-BUSY: assert a_rst between clock edges.
//     - Response: all outputs 0 immediately; after release, a re-issued I request at 0x44 completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port memory between fetch (read-only) and data (read/write) requesters
// Data wins contention except when fetch has waited MAX_D_STREAK data grants; every transaction is time-bounded.
module mem_arbiter #(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH_MEM   = 32,
  parameter int TIMEOUT      = 16,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                  a_clk,
  input  logic                  a_rst,
  input  logic                  a_i_i_req,
  input  logic [AWIDTH_MEM-1:0] a_i_i_addr,
  output logic                  a_o_i_ack,
  output logic [DWIDTH-1:0]     a_o_i_rdata,
  input  logic                  a_i_d_req,
  input  logic                  a_i_d_we,
  input  logic [AWIDTH_MEM-1:0] a_i_d_addr,
  input  logic [DWIDTH-1:0]     a_i_d_wdata,
  output logic                  a_o_d_ack,
  output logic [DWIDTH-1:0]     a_o_d_rdata,
  output logic                  a_o_m_req,
  output logic                  a_o_m_we,
  output logic [AWIDTH_MEM-1:0] a_o_m_addr,
  output logic [DWIDTH-1:0]     a_o_m_wdata,
  input  logic                  a_i_m_ack,
  input  logic [DWIDTH-1:0]     a_i_m_rdata,
  output logic                  a_o_err,
  output logic                  a_o_busy
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY_I = 2'd1;
  localparam logic [1:0] S_BUSY_D = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [SW-1:0]         streak_q, streak_d;
  logic                  m_req_q, m_req_d;
  logic                  m_we_q, m_we_d;
  logic [AWIDTH_MEM-1:0] m_addr_q, m_addr_d;
  logic [DWIDTH-1:0]     m_wdata_q, m_wdata_d;
  logic                  i_ack_q, i_ack_d;
  logic [DWIDTH-1:0]     i_rdata_q, i_rdata_d;
  logic                  d_ack_q, d_ack_d;
  logic [DWIDTH-1:0]     d_rdata_q, d_rdata_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;

  logic grant_d;
  logic done;

  // Fetch overrides data only once data has won MAX_D_STREAK times in a row against it.
  assign grant_d = a_i_d_req && !(a_i_i_req && (streak_q == STREAK_MAX));
  assign done    = a_i_m_ack || (tmo_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    streak_d  = streak_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_ack_d   = 1'b0;
    i_rdata_d = '0;
    d_ack_d   = 1'b0;
    d_rdata_d = '0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_d) begin
          state_d   = S_BUSY_D;
          tmo_d     = '0;
          m_req_d   = 1'b1;
          m_we_d    = a_i_d_we;
          m_addr_d  = a_i_d_addr;
          m_wdata_d = a_i_d_wdata;
          if (!a_i_i_req) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + SW'(1);
          end
        end else if (a_i_i_req) begin
          state_d   = S_BUSY_I;
          tmo_d     = '0;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = a_i_i_addr;
          m_wdata_d = '0;
          streak_d  = '0;
        end
      end
      S_BUSY_I, S_BUSY_D: begin
        if (done) begin
          state_d = S_RESP;
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
          err_d   = !a_i_m_ack;
          if (state_q == S_BUSY_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = a_i_m_ack ? a_i_m_rdata : '0;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = (a_i_m_ack && !m_we_q) ? a_i_m_rdata : '0;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      state_q   <= S_IDLE;
      tmo_q     <= '0;
      streak_q  <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_ack_q   <= 1'b0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      streak_q  <= streak_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_ack_q   <= i_ack_d;
      i_rdata_q <= i_rdata_d;
      d_ack_q   <= d_ack_d;
      d_rdata_q <= d_rdata_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign a_o_m_req   = m_req_q;
  assign a_o_m_we    = m_we_q;
  assign a_o_m_addr  = m_addr_q;
  assign a_o_m_wdata = m_wdata_q;
  assign a_o_i_ack   = i_ack_q;
  assign a_o_i_rdata = i_rdata_q;
  assign a_o_d_ack   = d_ack_q;
  assign a_o_d_rdata = d_rdata_q;
  assign a_o_err     = err_q;
  assign a_o_busy    = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
// Directed vector table, contention and reset sequences, then randomized traffic against a timeline model.
module tb_mem_arbiter;

  localparam int T    = 16;
  localparam int MAXS = 4;

  logic        a_clk = 1'b0;
  logic        a_rst = 1'b1;
  logic        a_i_i_req = 1'b0;
  logic [31:0] a_i_i_addr = '0;
  logic        a_o_i_ack;
  logic [31:0] a_o_i_rdata;
  logic        a_i_d_req = 1'b0;
  logic        a_i_d_we = 1'b0;
  logic [31:0] a_i_d_addr = '0;
  logic [31:0] a_i_d_wdata = '0;
  logic        a_o_d_ack;
  logic [31:0] a_o_d_rdata;
  logic        a_o_m_req;
  logic        a_o_m_we;
  logic [31:0] a_o_m_addr;
  logic [31:0] a_o_m_wdata;
  logic        a_i_m_ack = 1'b0;
  logic [31:0] a_i_m_rdata = '0;
  logic        a_o_err;
  logic        a_o_busy;

  mem_arbiter #(.DWIDTH(32), .AWIDTH_MEM(32), .TIMEOUT(T), .MAX_D_STREAK(MAXS)) dut (
    .a_clk(a_clk), .a_rst(a_rst),
    .a_i_i_req(a_i_i_req), .a_i_i_addr(a_i_i_addr), .a_o_i_ack(a_o_i_ack), .a_o_i_rdata(a_o_i_rdata),
    .a_i_d_req(a_i_d_req), .a_i_d_we(a_i_d_we), .a_i_d_addr(a_i_d_addr), .a_i_d_wdata(a_i_d_wdata),
    .a_o_d_ack(a_o_d_ack), .a_o_d_rdata(a_o_d_rdata),
    .a_o_m_req(a_o_m_req), .a_o_m_we(a_o_m_we), .a_o_m_addr(a_o_m_addr), .a_o_m_wdata(a_o_m_wdata),
    .a_i_m_ack(a_i_m_ack), .a_i_m_rdata(a_i_m_rdata),
    .a_o_err(a_o_err), .a_o_busy(a_o_busy)
  );

  always #5 a_clk = ~a_clk;

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    int          lat;
    logic [1:0]  exp_ack;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_hi;
  } vec_t;

  typedef struct {
    bit          valid;
    int          g;
    int          len;
    bit          side_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } txn_t;

  int n_cmp = 0;
  int n_err = 0;
  int mcnt = 0;
  int mem_lat = 1;
  bit noise = 1'b0;
  logic [31:0] mem [logic [31:0]];
  vec_t vecs[11];
  vec_t v44;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge a_clk);
    #1;
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory acks on the mem_lat-th cycle it sees a_o_m_req high; mem_lat==0 never acks.
  task automatic mem_step();
    if (a_o_m_req) begin
      mcnt++;
      if (mem_lat != 0 && mcnt == mem_lat) begin
        a_i_m_ack = 1'b1;
        if (a_o_m_we) begin
          mem[a_o_m_addr] = a_o_m_wdata;
          a_i_m_rdata = $urandom;
        end else begin
          a_i_m_rdata = mem_rd(a_o_m_addr);
        end
      end else begin
        a_i_m_ack = 1'b0;
        a_i_m_rdata = $urandom;
      end
    end else begin
      mcnt = 0;
      a_i_m_ack = noise && ($urandom_range(0, 3) == 0);
      a_i_m_rdata = $urandom;
    end
  endtask

  task automatic run_txn(input vec_t v, input int id);
    int  nhi = 0;
    int  t_ack = 0;
    bit  first = 1'b1;
    a_i_i_req = v.i_req;   a_i_i_addr = v.i_addr;
    a_i_d_req = v.d_req;   a_i_d_we = v.d_we;
    a_i_d_addr = v.d_addr; a_i_d_wdata = v.d_wdata;
    mem_lat = v.lat;
    for (int t = 1; t <= 40 && t_ack == 0; t++) begin
      tick();
      if (a_o_m_req) begin
        nhi++;
        if (first) begin
          first = 1'b0;
          check($sformatf("v%0d_m_addr", id), 64'(a_o_m_addr), 64'(v.exp_addr));
          check($sformatf("v%0d_m_we", id), 64'(a_o_m_we), 64'(v.exp_we));
          if (v.exp_we) check($sformatf("v%0d_m_wdata", id), 64'(a_o_m_wdata), 64'(v.exp_wdata));
        end
      end
      if (a_o_i_ack || a_o_d_ack) begin
        t_ack = t;
        check($sformatf("v%0d_ack_side", id), 64'({a_o_i_ack, a_o_d_ack}), 64'(v.exp_ack));
        check($sformatf("v%0d_rdata", id), 64'(a_o_i_ack ? a_o_i_rdata : a_o_d_rdata), 64'(v.exp_rdata));
        check($sformatf("v%0d_err", id), 64'(a_o_err), 64'(v.exp_err));
        check($sformatf("v%0d_busy_resp", id), 64'(a_o_busy), 64'd1);
        check($sformatf("v%0d_mreq_cycles", id), 64'(nhi), 64'(v.exp_hi));
        check($sformatf("v%0d_latency", id), 64'(t), 64'(v.exp_hi + 1));
        a_i_i_req = 1'b0;
        a_i_d_req = 1'b0;
      end
      mem_step();
    end
    if (t_ack == 0) check($sformatf("v%0d_ack_timeout", id), 64'd0, 64'd1);
    tick();
    mem_step();
    check($sformatf("v%0d_idle_after", id),
          64'({a_o_busy, a_o_m_req, a_o_m_we, a_o_i_ack, a_o_d_ack, a_o_err}), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bit          got[10];
    int          gcyc[10];
    int          ngr;
    bit          prev;
    bit          done;
    bit          i_pend;
    bit          d_pend;
    int          run;
    int          free_at;
    int          lat;
    bit          bph;
    bit          rph;
    txn_t        cur;

    mem[32'h40]  = 32'h2002_0005;
    mem[32'h200] = 32'h0000_1234;
    mem[32'h44]  = 32'h1357_9BDF;

    //            i_req  i_addr      d_req  d_we   d_addr      d_wdata        lat ack    we     m_addr      m_wdata        rdata          err    hi
    vecs[0]  = '{1'b1, 32'h40,     1'b0, 1'b0, 32'h0,      32'h0,         1,  2'b10, 1'b0, 32'h40,     32'h0,         32'h2002_0005, 1'b0, 1};
    vecs[1]  = '{1'b0, 32'h0,      1'b1, 1'b1, 32'h100,    32'hDEAD_BEEF, 1,  2'b01, 1'b1, 32'h100,    32'hDEAD_BEEF, 32'h0,         1'b0, 1};
    vecs[2]  = '{1'b0, 32'h0,      1'b1, 1'b0, 32'h100,    32'h0,         3,  2'b01, 1'b0, 32'h100,    32'h0,         32'hDEAD_BEEF, 1'b0, 3};
    vecs[3]  = '{1'b0, 32'h0,      1'b1, 1'b0, 32'h300,    32'h0,         0,  2'b01, 1'b0, 32'h300,    32'h0,         32'h0,         1'b1, T};
    vecs[4]  = '{1'b0, 32'h0,      1'b1, 1'b0, 32'h200,    32'h0,         T,  2'b01, 1'b0, 32'h200,    32'h0,         32'h0000_1234, 1'b0, T};
    vecs[5]  = '{1'b0, 32'h0,      1'b1, 1'b0, 32'h200,    32'h0,         T+1,2'b01, 1'b0, 32'h200,    32'h0,         32'h0,         1'b1, T};
    vecs[6]  = '{1'b0, 32'h0,      1'b1, 1'b1, 32'h104,    32'hCAFE_F00D, T-1,2'b01, 1'b1, 32'h104,    32'hCAFE_F00D, 32'h0,         1'b0, T-1};
    vecs[7]  = '{1'b1, 32'h104,    1'b0, 1'b0, 32'h0,      32'h0,         1,  2'b10, 1'b0, 32'h104,    32'h0,         32'hCAFE_F00D, 1'b0, 1};
    vecs[8]  = '{1'b1, 32'h500,    1'b0, 1'b0, 32'h0,      32'h0,         0,  2'b10, 1'b0, 32'h500,    32'h0,         32'h0,         1'b1, T};
    vecs[9]  = '{1'b0, 32'h0,      1'b1, 1'b1, 32'h40,     32'hBAD0_BAD0, 0,  2'b01, 1'b1, 32'h40,     32'hBAD0_BAD0, 32'h0,         1'b1, T};
    vecs[10] = '{1'b1, 32'h40,     1'b0, 1'b0, 32'h0,      32'h0,         2,  2'b10, 1'b0, 32'h40,     32'h0,         32'h2002_0005, 1'b0, 2};
    v44      = '{1'b1, 32'h44,     1'b0, 1'b0, 32'h0,      32'h0,         1,  2'b10, 1'b0, 32'h44,     32'h0,         32'h1357_9BDF, 1'b0, 1};

    tick();
    tick();
    check("reset_ctrl", 64'({a_o_busy, a_o_m_req, a_o_m_we, a_o_i_ack, a_o_d_ack, a_o_err}), 64'd0);
    check("reset_data", 64'(|{a_o_m_addr, a_o_m_wdata, a_o_i_rdata, a_o_d_rdata}), 64'd0);
    a_rst = 1'b0;

    for (int n = 0; n < 11; n++) run_txn(vecs[n], n);

    // Both requesters held continuously against a zero-wait memory.
    a_i_i_addr = 32'h1000;
    a_i_d_we = 1'b0; a_i_d_addr = 32'h2000;
    a_i_i_req = 1'b1; a_i_d_req = 1'b1;
    mem_lat = 1; ngr = 0; prev = 1'b0; done = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      tick();
      if (a_o_m_req && !prev) begin
        if (ngr < 10) begin
          got[ngr] = (a_o_m_addr == 32'h1000);
          gcyc[ngr] = c;
        end
        ngr++;
      end
      prev = a_o_m_req;
      mem_step();
      if (ngr >= 10 && a_o_i_ack) a_i_i_req = 1'b0;
      if (ngr >= 11 && a_o_d_ack) begin
        a_i_d_req = 1'b0;
        done = 1'b1;
      end
    end
    check("contention_done", 64'(done), 64'd1);
    for (int k = 0; k < 10; k++)
      check($sformatf("grant%0d_is_fetch", k), 64'(got[k]), 64'((k % 5) == 4));
    check("contention_period", 64'(gcyc[9] - gcyc[0]), 64'd27);
    tick();
    mem_step();
    check("contention_idle", 64'(a_o_busy), 64'd0);

    // Reset asserted between edges while a fetch is stalled in BUSY.
    a_i_i_req = 1'b1; a_i_i_addr = 32'h60; mem_lat = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      mem_step();
    end
    check("pre_reset_busy", 64'({a_o_m_req, a_o_busy}), 64'd3);
    #2;
    a_rst = 1'b1;
    a_i_i_req = 1'b0;
    #1;
    check("async_reset_ctrl", 64'({a_o_busy, a_o_m_req, a_o_m_we, a_o_i_ack, a_o_d_ack, a_o_err}), 64'd0);
    check("async_reset_data", 64'(|{a_o_m_addr, a_o_m_wdata, a_o_i_rdata, a_o_d_rdata}), 64'd0);
    tick();
    a_rst = 1'b0;
    mem_step();
    run_txn(v44, 44);

    // Randomized traffic; the model predicts each transaction's full timeline at grant time.
    noise = 1'b1; i_pend = 1'b0; d_pend = 1'b0; run = 0; free_at = 0;
    cur = '{valid: 1'b0, g: 0, len: 0, side_d: 1'b0, we: 1'b0, addr: '0, wdata: '0, rdata: '0, err: 1'b0};
    for (int k = 0; k < 3000; k++) begin
      tick();
      bph = cur.valid && (k > cur.g) && (k <= cur.g + cur.len);
      rph = cur.valid && (k == cur.g + cur.len + 1);
      check("rnd_ctrl", 64'({a_o_m_req, a_o_m_we, a_o_i_ack, a_o_d_ack, a_o_err, a_o_busy}),
            64'({bph, bph & cur.we, rph & !cur.side_d, rph & cur.side_d, rph & cur.err, bph | rph}));
      if (bph) begin
        check("rnd_m_addr", 64'(a_o_m_addr), 64'(cur.addr));
        if (cur.we) check("rnd_m_wdata", 64'(a_o_m_wdata), 64'(cur.wdata));
      end
      if (rph) check("rnd_rdata", 64'(cur.side_d ? a_o_d_rdata : a_o_i_rdata), 64'(cur.rdata));
      mem_step();
      if (a_o_i_ack) i_pend = 1'b0;
      if (a_o_d_ack) d_pend = 1'b0;
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1'b1;
        a_i_i_addr = 32'($urandom_range(0, 31)) << 2;
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1'b1;
        a_i_d_we = 1'($urandom_range(0, 1));
        a_i_d_addr = 32'($urandom_range(0, 31)) << 2;
        a_i_d_wdata = $urandom;
      end
      a_i_i_req = i_pend;
      a_i_d_req = d_pend;
      if (k >= free_at && (a_i_i_req || a_i_d_req)) begin
        cur.valid = 1'b1;
        cur.g = k;
        cur.side_d = a_i_d_req && !(a_i_i_req && run == MAXS);
        if (cur.side_d) run = a_i_i_req ? ((run < MAXS) ? run + 1 : MAXS) : 0;
        else run = 0;
        cur.we = cur.side_d && a_i_d_we;
        cur.addr = cur.side_d ? a_i_d_addr : a_i_i_addr;
        cur.wdata = a_i_d_wdata;
        lat = $urandom_range(1, T + 2);
        cur.err = (lat > T);
        cur.len = cur.err ? T : lat;
        cur.rdata = (cur.err || cur.we) ? 32'h0 : mem_rd(cur.addr);
        mem_lat = lat;
        free_at = k + cur.len + 2;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
